prio_out_scheduler: RTL and testbench
=====================================

Name: prio_out_scheduler

Overview:
- Per-output-port egress scheduler. Arbitrates among NUM_PRI priority queues of one output port and streams whole packets onto the rd_* interface.
- Strict-priority (SP) or weighted round-robin (WRR) mode, selected by sp0_wrr1. WRR weights are programmable per priority.
- One instance per output port, between the per-priority packet queues and the port's rd_sop/rd_eop/rd_vld/rd_data outputs.
- Packet-granular: a grant is held from sop to eop.

Parameters:
- NUM_PRI, 8, number of priority queues per port; index NUM_PRI-1 is highest.
- PRI_W, 3, width of a priority index (clog2 NUM_PRI).
- DATA_W, 64, data word width.
- WEIGHT_W, 4, width of one WRR weight or credit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- sp0_wrr1  in  1  mode select: 0 = SP, 1 = WRR.
- wrr_weight  in  NUM_PRI*WEIGHT_W  packed per-priority weights; slice p belongs to priority p.
- q_valid  in  NUM_PRI  queue p head word is valid.
- q_data  in  NUM_PRI*DATA_W  head word of each queue.
- q_eop  in  NUM_PRI  head word of queue p is the last word of its packet.
- ready  in  NUM_PRI  downstream accepts traffic of priority p.
- q_rd  out  NUM_PRI  pop strobe for queue p (combinational).
- rd_sop  out  1  first word of packet (registered).
- rd_eop  out  1  last word of packet (registered).
- rd_vld  out  1  rd_data valid (registered).
- rd_data  out  DATA_W  output word (registered).
- grant_pri  out  PRI_W  priority currently or last granted.
- busy  out  1  high while in XFER.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; all outputs 0, including grant_pri.
  - q_rd = 0 immediately.
  - Credits reload to weights; rr_ptr = 0; first_word = 1.
  - Reset mid-packet abandons the packet. No eop is emitted.
- Eligibility: elig[p] = q_valid[p] & ready[p].
- FSM states: IDLE, XFER.
- IDLE, SP mode (sp0_wrr1=0):
  - If any elig, grant = highest-index eligible p.
  - Latch grant_pri, go to XFER. No pop in this cycle.
  - Credits are held at their weights every cycle.
- IDLE, WRR mode (sp0_wrr1=1):
  - Candidates are eligible p with credit[p] != 0.
  - Scan circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ... mod NUM_PRI); first candidate wins. Go to XFER.
  - If elig != 0 but no candidate exists: reload every credit from its weight this cycle, stay in IDLE, no grant. Arbitrate next cycle.
  - A weight of 0 is treated as 1.
- sp0_wrr1 and wrr_weight are sampled only in IDLE. Changes during XFER take effect at the next arbitration.
- XFER (g = grant_pri):
  - q_rd[g] = q_valid[g] & ready[g]. All other q_rd bits are 0.
  - Cycle after a pop: rd_vld=1, rd_data=q_data[g], rd_eop=q_eop[g], rd_sop=first_word. Then clear first_word.
  - Cycle with no pop (queue empty mid-packet or ready[g]=0): next cycle rd_vld=rd_sop=rd_eop=0, rd_data holds. first_word is unchanged, so sop is never repeated.
  - Pop of a word with q_eop[g]=1:
    - In WRR mode, credit[g] decrements by 1. If the result is 0, rr_ptr = g+1 (mod NUM_PRI), otherwise rr_ptr is unchanged.
    - Set first_word=1 and return to IDLE.
  - Single-word packet (sop and eop on the same word) is legal: rd_sop=rd_eop=1 in the same cycle.
- Latency: grant cycle + 1 pop cycle + 1 output register. First rd_vld appears 2 cycles after elig rises in IDLE.
- Minimum inter-packet gap: 1 idle cycle (the IDLE arbitration cycle).
- busy = (state==XFER).
- Simultaneous eop pop and new elig: the new packet is arbitrated in the following IDLE cycle. No back-to-back skip.

Test Plan:
- Reset/idle: rst=0 mid-packet then release → all outputs 0, q_rd=0 asynchronously, busy=0; next packet starts with rd_sop=1.
- SP: sp0_wrr1=0; queues 2 and 5 each hold a 3-word packet, all ready → grant_pri=5 first. rd_vld for 3 cycles, sop on word 0, eop on word 2. Then 1 gap cycle, then priority 2's packet.
- WRR: sp0_wrr1=1, weights p0=2, p1=1, others 0; p0/p1 continuously backlogged with 1-word packets → grant order 0,0,1, reload cycle, 0,0,1.
- Backpressure: 4-word packet on p3; ready[3]=0 for 2 cycles after word 1 → rd_vld=0 for exactly 2 cycles, no second sop, eop on word 3, total 4 vld cycles.
- Mid-packet starvation: q_valid[g] drops for 3 cycles inside a packet → q_rd=0 during the gap, grant held. A higher-priority packet arriving meanwhile waits until eop.
- Mode switch: toggle sp0_wrr1 during XFER → current packet completes unchanged. The new mode governs the next grant.

Source files
------------

// File: rtl/prio_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : prio_out_scheduler
// Function : Per-output-port egress scheduler. Strict-priority or weighted
//            round-robin arbitration over NUM_PRI queues, packet-granular.
// Revision : 1.0 - initial release
// ============================================================================
module prio_out_scheduler #(
    parameter int NUM_PRI  = 8,
    parameter int PRI_W    = 3,
    parameter int DATA_W   = 64,
    parameter int WEIGHT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sp0_wrr1,
    input  logic [NUM_PRI*WEIGHT_W-1:0] wrr_weight,
    input  logic [NUM_PRI-1:0]          q_valid,
    input  logic [NUM_PRI*DATA_W-1:0]   q_data,
    input  logic [NUM_PRI-1:0]          q_eop,
    input  logic [NUM_PRI-1:0]          ready,
    output logic [NUM_PRI-1:0]          q_rd,
    output logic                        rd_sop,
    output logic                        rd_eop,
    output logic                        rd_vld,
    output logic [DATA_W-1:0]           rd_data,
    output logic [PRI_W-1:0]            grant_pri,
    output logic                        busy
);

    localparam logic [0:0]         c_ST_IDLE = 1'b0;
    localparam logic [0:0]         c_ST_XFER = 1'b1;
    localparam logic [NUM_PRI-1:0] c_PRI_LSB = NUM_PRI'(1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [NUM_PRI-1:0]  w_elig;
    logic [NUM_PRI-1:0]  w_cand;
    logic [WEIGHT_W-1:0] w_weight [NUM_PRI];
    logic [DATA_W-1:0]   w_qdata  [NUM_PRI];
    // Credit is kept as a consumed count: credit = weight - used, so reset
    // and reload both clear to a constant.
    logic [WEIGHT_W-1:0] r_used   [NUM_PRI];
    logic                w_sp_found;
    logic                w_wrr_found;
    logic                w_grant;
    logic                w_reload;
    logic [PRI_W-1:0]    w_sp_pri;
    logic [PRI_W-1:0]    w_wrr_pri;
    logic [PRI_W-1:0]    w_sel_pri;
    logic [PRI_W-1:0]    w_ptr_nxt;
    logic [PRI_W-1:0]    r_rr_ptr;
    logic [WEIGHT_W-1:0] r_gweight;
    logic                r_mode;
    logic                r_first;
    logic                w_pop;
    logic                w_eop_pop;

    assign w_elig = q_valid & ready;

    generate
        for (genvar p = 0; p < NUM_PRI; p++) begin : g_pri
            logic [WEIGHT_W-1:0] w_raw;
            assign w_raw       = wrr_weight[p*WEIGHT_W +: WEIGHT_W];
            assign w_weight[p] = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
            assign w_qdata[p]  = q_data[p*DATA_W +: DATA_W];
            assign w_cand[p]   = w_elig[p] & (r_used[p] < w_weight[p]);
        end
    endgenerate

    always_comb begin
        w_sp_found = 1'b0;
        w_sp_pri   = '0;
        for (int p = 0; p < NUM_PRI; p++) begin
            if (w_elig[p]) begin
                w_sp_found = 1'b1;
                w_sp_pri   = PRI_W'(p);
            end
        end
    end

    // Circular scan starting at the round-robin pointer.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_wrr_found = 1'b0;
        w_wrr_pri   = '0;
        for (int i = 0; i < NUM_PRI; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NUM_PRI) begin
                v_idx = v_idx - NUM_PRI;
            end
            if (!w_wrr_found && w_cand[v_idx]) begin
                w_wrr_found = 1'b1;
                w_wrr_pri   = PRI_W'(v_idx);
            end
        end
    end

    assign w_grant   = sp0_wrr1 ? w_wrr_found : w_sp_found;
    assign w_sel_pri = sp0_wrr1 ? w_wrr_pri : w_sp_pri;
    assign w_reload  = sp0_wrr1 & (|w_elig) & ~w_wrr_found;
    assign w_pop     = (r_state == c_ST_XFER) & q_valid[grant_pri] & ready[grant_pri];
    assign w_eop_pop = w_pop & q_eop[grant_pri];
    assign w_ptr_nxt = (grant_pri == PRI_W'(NUM_PRI - 1)) ? '0 : grant_pri + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_grant)   w_state_nxt = c_ST_XFER;
            c_ST_XFER: if (w_eop_pop) w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        q_rd = w_pop ? (c_PRI_LSB << grant_pri) : '0;
        busy = (r_state == c_ST_XFER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_pri <= '0;
            r_mode    <= 1'b0;
            r_gweight <= '0;
            r_rr_ptr  <= '0;
            r_first   <= 1'b1;
            rd_vld    <= 1'b0;
            rd_sop    <= 1'b0;
            rd_eop    <= 1'b0;
            rd_data   <= '0;
            for (int p = 0; p < NUM_PRI; p++) begin
                r_used[p] <= '0;
            end
        end else begin
            rd_vld <= w_pop;
            rd_sop <= w_pop & r_first;
            rd_eop <= w_eop_pop;
            if (w_pop) begin
                rd_data <= w_qdata[grant_pri];
                r_first <= q_eop[grant_pri];
            end
            if (r_state == c_ST_IDLE) begin
                if (!sp0_wrr1 || w_reload) begin
                    for (int p = 0; p < NUM_PRI; p++) begin
                        r_used[p] <= '0;
                    end
                end
                if (w_grant) begin
                    grant_pri <= w_sel_pri;
                    r_mode    <= sp0_wrr1;
                    r_gweight <= w_weight[w_sel_pri];
                end
            end
            // Mode latched at grant decides whether the packet spends credit.
            if (w_eop_pop && r_mode) begin
                r_used[grant_pri] <= r_used[grant_pri] + 1'b1;
                if ((r_used[grant_pri] + 1'b1) >= r_gweight) begin
                    r_rr_ptr <= w_ptr_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_out_scheduler
// Function : Self-checking bench for prio_out_scheduler (vector table,
//            directed corner sequences, randomized run against a model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_out_scheduler;

    localparam int NUM_PRI  = 8;
    localparam int PRI_W    = 3;
    localparam int DATA_W   = 64;
    localparam int WEIGHT_W = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        sp0_wrr1 = 1'b0;
    logic [NUM_PRI*WEIGHT_W-1:0] wrr_weight = '0;
    logic [NUM_PRI-1:0]          q_valid = '0;
    logic [NUM_PRI*DATA_W-1:0]   q_data = '0;
    logic [NUM_PRI-1:0]          q_eop = '0;
    logic [NUM_PRI-1:0]          ready = '0;
    logic [NUM_PRI-1:0]          q_rd;
    logic                        rd_sop;
    logic                        rd_eop;
    logic                        rd_vld;
    logic [DATA_W-1:0]           rd_data;
    logic [PRI_W-1:0]            grant_pri;
    logic                        busy;

    prio_out_scheduler #(
        .NUM_PRI  (NUM_PRI),
        .PRI_W    (PRI_W),
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sp0_wrr1   (sp0_wrr1),
        .wrr_weight (wrr_weight),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .q_eop      (q_eop),
        .ready      (ready),
        .q_rd       (q_rd),
        .rd_sop     (rd_sop),
        .rd_eop     (rd_eop),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .grant_pri  (grant_pri),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Queue contents: {eop, data} per word.
    logic [DATA_W:0]    qw [NUM_PRI][$];
    logic [NUM_PRI-1:0] hold = '0;
    logic [NUM_PRI-1:0] seen_qrd = '0;
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit                 m_busy, m_first, m_mode;
    int                 m_g, m_ptr;
    int                 m_cred [NUM_PRI];
    bit                 m_vld, m_sop, m_eop;
    logic [DATA_W-1:0]  m_data;
    logic [NUM_PRI-1:0] exp_qrd;

    typedef struct {
        bit                 load;
        int                 lpri;
        int                 llen;
        logic [NUM_PRI-1:0] rdy;
        logic [NUM_PRI-1:0] e_qrd;
        bit                 e_vld;
        bit                 e_sop;
        bit                 e_eop;
        logic [15:0]        e_data;
        int                 e_grant;
        bit                 e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    function automatic int eff_w(input int p);
        int w;
        w = int'(wrr_weight[p*WEIGHT_W +: WEIGHT_W]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_first = 1'b1;
        m_mode  = 1'b0;
        m_g     = 0;
        m_ptr   = 0;
        m_vld   = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        m_data  = '0;
        for (int i = 0; i < NUM_PRI; i++) m_cred[i] = eff_w(i);
    endtask

    // One cycle of the scheduling rules, from the inputs about to be clocked.
    task automatic model_step();
        logic [NUM_PRI-1:0] elig;
        bit found;
        int p;
        elig    = q_valid & ready;
        exp_qrd = '0;
        m_vld   = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        if (!m_busy) begin
            if (!sp0_wrr1) begin
                for (int i = 0; i < NUM_PRI; i++) m_cred[i] = eff_w(i);
                for (int i = 0; i < NUM_PRI; i++) begin
                    if (elig[i]) begin
                        m_g = i; m_busy = 1'b1; m_mode = 1'b0;
                    end
                end
            end else begin
                found = 1'b0;
                for (int i = 0; i < NUM_PRI; i++) begin
                    p = (m_ptr + i) % NUM_PRI;
                    if (!found && elig[p] && m_cred[p] != 0) begin
                        found = 1'b1; m_g = p;
                    end
                end
                if (found) begin
                    m_busy = 1'b1; m_mode = 1'b1;
                end else if (elig != '0) begin
                    for (int i = 0; i < NUM_PRI; i++) m_cred[i] = eff_w(i);
                end
            end
        end else if (q_valid[m_g] && ready[m_g]) begin
            exp_qrd[m_g] = 1'b1;
            m_vld   = 1'b1;
            m_sop   = m_first;
            m_eop   = q_eop[m_g];
            m_data  = q_data[m_g*DATA_W +: DATA_W];
            m_first = 1'b0;
            if (m_eop) begin
                if (m_mode) begin
                    m_cred[m_g]--;
                    if (m_cred[m_g] == 0) m_ptr = (m_g + 1) % NUM_PRI;
                end
                m_first = 1'b1;
                m_busy  = 1'b0;
            end
        end
    endtask

    task automatic drive();
        logic [DATA_W:0] h;
        for (int p = 0; p < NUM_PRI; p++) begin
            if (qw[p].size() > 0) begin
                h = qw[p][0];
                q_valid[p] = ~hold[p];
                q_data[p*DATA_W +: DATA_W] = h[DATA_W-1:0];
                q_eop[p] = h[DATA_W];
            end else begin
                q_valid[p] = 1'b0;
                q_eop[p]   = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int p, input int len, input logic [DATA_W-1:0] base);
        for (int w = 0; w < len; w++) begin
            qw[p].push_back({(w == len - 1), base + DATA_W'(w)});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        model_step();
        chk("q_rd", 64'(q_rd), 64'(exp_qrd));
        seen_qrd = q_rd;
        @(posedge clk);
        for (int p = 0; p < NUM_PRI; p++) begin
            if (seen_qrd[p] && qw[p].size() > 0) void'(qw[p].pop_front());
        end
        #1;
        chk("rd_vld", 64'(rd_vld), 64'(m_vld));
        chk("rd_sop", 64'(rd_sop), 64'(m_sop));
        chk("rd_eop", 64'(rd_eop), 64'(m_eop));
        chk("rd_data", rd_data, m_data);
        chk("grant_pri", 64'(grant_pri), 64'(m_g));
        chk("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_q_rd", 64'(q_rd), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_vld", 64'(rd_vld), 64'(0));
        chk("rst_sop", 64'(rd_sop), 64'(0));
        chk("rst_eop", 64'(rd_eop), 64'(0));
        chk("rst_data", rd_data, 64'(0));
        chk("rst_grant", 64'(grant_pri), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input bit ld, input int lp, input int ll,
                                input logic [7:0] rdy, input logic [7:0] qrd,
                                input bit v, input bit s, input bit e,
                                input logic [15:0] d, input int g, input bit b);
        vec_t r;
        r.load = ld; r.lpri = lp; r.llen = ll; r.rdy = rdy; r.e_qrd = qrd;
        r.e_vld = v; r.e_sop = s; r.e_eop = e; r.e_data = d;
        r.e_grant = g; r.e_busy = b;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int prev_busy;
        int gl [6];
        int gt [6];
        int exp_g [6];
        int exp_d [5];

        // SP: p5 then p2, then backpressure on a 4-word p3 packet.
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 16'h000, 5, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h20, 1, 1, 0, 16'h500, 5, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h20, 1, 0, 0, 16'h501, 5, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h20, 1, 0, 1, 16'h502, 5, 0));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 16'h502, 2, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h04, 1, 1, 0, 16'h200, 2, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h04, 1, 0, 0, 16'h201, 2, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h04, 1, 0, 1, 16'h202, 2, 0));
        tbl.push_back(mk(1, 3, 4, 8'hFF, 8'h00, 0, 0, 0, 16'h202, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h08, 1, 1, 0, 16'h300, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h08, 1, 0, 0, 16'h301, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hF7, 8'h00, 0, 0, 0, 16'h301, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hF7, 8'h00, 0, 0, 0, 16'h301, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h08, 1, 0, 0, 16'h302, 3, 1));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h08, 1, 0, 1, 16'h303, 3, 0));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 16'h303, 3, 0));

        wrr_weight = 32'h1111_1111;
        sp0_wrr1   = 1'b0;
        do_reset();
        push_pkt(2, 3, 64'h200);
        push_pkt(5, 3, 64'h500);
        foreach (tbl[i]) begin
            if (tbl[i].load) push_pkt(tbl[i].lpri, tbl[i].llen, 64'(tbl[i].lpri * 256));
            ready = tbl[i].rdy;
            tick();
            chk("tbl_q_rd", 64'(seen_qrd), 64'(tbl[i].e_qrd));
            chk("tbl_vld", 64'(rd_vld), 64'(tbl[i].e_vld));
            chk("tbl_sop", 64'(rd_sop), 64'(tbl[i].e_sop));
            chk("tbl_eop", 64'(rd_eop), 64'(tbl[i].e_eop));
            chk("tbl_data", rd_data, 64'(tbl[i].e_data));
            chk("tbl_grant", 64'(grant_pri), 64'(tbl[i].e_grant));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
        end

        // Reset in the middle of a packet, then a fresh packet must start with sop.
        ready = '1;
        push_pkt(6, 4, 64'h600);
        repeat (3) tick();
        do_reset();
        qw[6].delete();
        push_pkt(6, 2, 64'h6A0);
        tick();
        tick();
        chk("reset_new_sop", 64'(rd_sop), 64'(1));
        chk("reset_new_data", rd_data, 64'h6A0);
        tick();
        chk("reset_new_eop", 64'(rd_eop), 64'(1));

        // Mid-packet starvation with a higher priority arriving during the gap.
        push_pkt(1, 3, 64'h100);
        tick();
        tick();
        hold[1] = 1'b1;
        push_pkt(6, 2, 64'h6B0);
        repeat (3) begin
            tick();
            chk("starve_q_rd", 64'(seen_qrd), 64'(0));
            chk("starve_grant", 64'(grant_pri), 64'(1));
            chk("starve_vld", 64'(rd_vld), 64'(0));
        end
        hold[1] = 1'b0;
        tick();
        tick();
        chk("starve_eop", 64'(rd_eop), 64'(1));
        chk("starve_eop_data", rd_data, 64'h102);
        tick();
        chk("starve_next_grant", 64'(grant_pri), 64'(6));
        tick();
        tick();

        // WRR with weights p0=2, p1=1: 0,0,1, reload, 0,0,1.
        wrr_weight = 32'h0000_0012;
        sp0_wrr1   = 1'b1;
        do_reset();
        got = 0;
        prev_busy = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (qw[0].size() < 2) push_pkt(0, 1, 64'hA000 + 64'(c));
            if (qw[1].size() < 2) push_pkt(1, 1, 64'hB000 + 64'(c));
            tick();
            if (busy && prev_busy == 0) begin
                gl[got] = int'(grant_pri);
                gt[got] = c;
                got++;
            end
            prev_busy = int'(busy);
        end
        chk("wrr_grant_count", 64'(got), 64'(6));
        exp_g = '{0, 0, 1, 0, 0, 1};
        exp_d = '{2, 2, 3, 2, 2};
        for (int i = 0; i < 6 && i < got; i++) chk("wrr_order", 64'(gl[i]), 64'(exp_g[i]));
        for (int i = 0; i < 5 && i + 1 < got; i++) chk("wrr_spacing", 64'(gt[i+1] - gt[i]), 64'(exp_d[i]));

        // Mode switch during XFER: packet completes, next grant follows WRR.
        qw[0].delete();
        qw[1].delete();
        wrr_weight = 32'h1111_1111;
        sp0_wrr1   = 1'b0;
        do_reset();
        push_pkt(4, 3, 64'h400);
        tick();
        sp0_wrr1 = 1'b1;
        tick();
        tick();
        push_pkt(0, 1, 64'h0C0);
        push_pkt(7, 1, 64'h7C0);
        tick();
        chk("mode_eop", 64'(rd_eop), 64'(1));
        chk("mode_grant_held", 64'(grant_pri), 64'(4));
        tick();
        chk("mode_next_grant", 64'(grant_pri), 64'(0));
        tick();
        tick();
        chk("mode_then_grant", 64'(grant_pri), 64'(7));
        tick();

        // Randomized segments checked against the model.
        for (int seg = 0; seg < 4; seg++) begin
            for (int p = 0; p < NUM_PRI; p++) qw[p].delete();
            hold       = '0;
            wrr_weight = $urandom() & 32'h3333_3333;
            sp0_wrr1   = seg[0];
            do_reset();
            for (int c = 0; c < 700; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int p;
                    p = $urandom_range(0, NUM_PRI - 1);
                    if (qw[p].size() < 12)
                        push_pkt(p, $urandom_range(1, 4), {$urandom(), $urandom()});
                end
                for (int p = 0; p < NUM_PRI; p++) begin
                    ready[p] = ($urandom_range(0, 4) != 0);
                    hold[p]  = ($urandom_range(0, 9) == 0);
                end
                if ($urandom_range(0, 49) == 0) sp0_wrr1 = ~sp0_wrr1;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
